// File: rtl/ff_line_doubler.sv
// Line doubler for the ff core: buffers each 15 kHz input line in ping-pong RAM
// and replays it twice at the 2x pixel rate, expanding 3-3-2 colour to 8-8-8.
module ff_line_doubler #(
  parameter int unsigned LINE_MAX     = 512,
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned CNT_W        = 11,
  parameter int unsigned H_PERIOD_DEF = 384,
  parameter int unsigned MIN_PERIOD   = 64,
  parameter int unsigned HS_W         = 23,
  parameter int unsigned H_START      = 48
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_in,
  input  logic       ce_out,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic       blank_i,
  input  logic [7:0] rgb_i,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       blank_o,
  output logic [7:0] r_o,
  output logic [7:0] g_o,
  output logic [7:0] b_o,
  output logic       overflow_o
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CMP_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [7:0]       mem [0:2*LINE_MAX-1];
  logic             wr_sel;
  logic [LEN_W-1:0] wr_addr;
  logic [LEN_W-1:0] line_len;
  logic [CNT_W-1:0] h_period;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_h;
  logic             vs_pipe;
  logic             hs_prev;
  logic             hs_s1;
  logic             act_s1;
  logic [7:0]       rd_data;

  logic             hs_edge;
  logic             wr_full;
  logic             wr_en;
  logic             period_ok;
  logic             act;
  logic             hs_act;
  logic [CNT_W-1:0] in_cnt_inc;
  logic [CNT_W-1:0] out_h_nxt;
  logic [ADDR_W-1:0] rd_addr;

  // Decode of write-side events and read-side position.
  always_comb begin
    hs_edge    = ce_in & hsync_i & ~hs_prev;
    wr_full    = (wr_addr == LEN_W'(LINE_MAX));
    wr_en      = ce_in & ~blank_i & ~wr_full;
    // Saturating increment doubles as the measured period, so 2^CNT_W never wraps to 0.
    in_cnt_inc = (in_cnt == CNT_MAX) ? CNT_MAX : in_cnt + CNT_W'(1);
    period_ok  = (in_cnt_inc >= CNT_W'(MIN_PERIOD));
    out_h_nxt  = (CMP_W'(out_h) + CMP_W'(1) >= CMP_W'(h_period)) ? '0 : out_h + CNT_W'(1);
    hs_act     = (out_h < CNT_W'(HS_W));
    act        = (out_h >= CNT_W'(H_START)) &&
                 (CMP_W'(out_h) < CMP_W'(H_START) + CMP_W'(line_len));
    rd_addr    = ADDR_W'(out_h - CNT_W'(H_START));
  end

  // Ping-pong line store: write half selected by wr_sel, read the other half.
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[{wr_sel, wr_addr[ADDR_W-1:0]}] <= rgb_i;
    if (ce_out) rd_data <= mem[{~wr_sel, rd_addr}];
  end

  // Input side: pixel capture, line length and period measurement.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_prev    <= 1'b0;
      wr_sel     <= 1'b0;
      wr_addr    <= '0;
      line_len   <= '0;
      h_period   <= CNT_W'(H_PERIOD_DEF);
      in_cnt     <= '0;
      vs_pipe    <= 1'b0;
      overflow_o <= 1'b0;
    end else if (ce_in) begin
      hs_prev <= hsync_i;
      if (!blank_i && wr_full) overflow_o <= 1'b1;
      if (hs_edge) begin
        line_len <= wr_addr;
        wr_sel   <= ~wr_sel;
        wr_addr  <= '0;
        in_cnt   <= '0;
        vs_pipe  <= vsync_i;
        if (period_ok) h_period <= in_cnt_inc;
      end else begin
        in_cnt <= in_cnt_inc;
        if (wr_en) wr_addr <= wr_addr + LEN_W'(1);
      end
    end
  end

  assign vsync_o = vs_pipe;

  // Output side: position counter, then RAM-read stage, then output register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      out_h   <= '0;
      hs_s1   <= 1'b0;
      act_s1  <= 1'b0;
      hsync_o <= 1'b0;
      blank_o <= 1'b1;
      r_o     <= '0;
      g_o     <= '0;
      b_o     <= '0;
    end else if (ce_out) begin
      out_h   <= hs_edge ? '0 : out_h_nxt;
      hs_s1   <= hs_act;
      act_s1  <= act & ~hs_act;
      hsync_o <= hs_s1;
      blank_o <= ~act_s1;
      if (act_s1) begin
        r_o <= {rd_data[2:0], rd_data[2:0], rd_data[2:1]};
        g_o <= {rd_data[5:3], rd_data[5:3], rd_data[5:4]};
        b_o <= {4{rd_data[7:6]}};
      end else begin
        r_o <= '0;
        g_o <= '0;
        b_o <= '0;
      end
    end
  end

endmodule

// File: doc/ff_line_doubler.md
Name: ff_line_doubler

Overview:
- Converts the 15 kHz game video (o_hsync/o_vsync/o_blank/o_rgb of the ff core, 3-3-2 RGB at the 6 MHz pixel rate) into a line-doubled 31 kHz stream.
- Sits directly downstream of the ff core and drives VGA_R/G/B, VGA_HS, VGA_VS and VGA_DE.
- Runs on a single clock (clk_sys), with input and output pixel rates set by clock enables.
- Buffers one line in ping-pong RAM and plays each buffered line twice at double pixel rate; also expands 3-3-2 colour to 8-8-8 by bit replication.

Parameters:
- LINE_MAX, 512, pixel capacity of each line buffer (power of two)
- ADDR_W, 9, log2(LINE_MAX)
- CNT_W, 11, width of the line-period counters
- H_PERIOD_DEF, 384, line period in ce_in ticks used after reset until the first valid measurement
- MIN_PERIOD, 64, measured periods below this are rejected
- HS_W, 23, output hsync width in ce_out ticks
- H_START, 48, ce_out tick within the output line where active video begins

Ports:
- clk_sys  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high reset
- ce_in  in  1  input pixel enable, 6 MHz rate; every ce_in cycle also has ce_out=1
- ce_out  in  1  output pixel enable, exactly 2x the ce_in rate
- hsync_i  in  1  input hsync, active high
- vsync_i  in  1  input vsync, active high
- blank_i  in  1  input blank, high = not visible
- rgb_i  in  8  {B[1:0],G[2:0],R[2:0]}
- hsync_o  out  1  output hsync, active high
- vsync_o  out  1  output vsync, active high
- blank_o  out  1  output blank
- r_o  out  8  red, bit-replicated
- g_o  out  8  green, bit-replicated
- b_o  out  8  blue, bit-replicated
- overflow_o  out  1  sticky: a line exceeded LINE_MAX active pixels

Behaviour:
- Reset values:
  - Outputs: hsync_o=0, vsync_o=0, blank_o=1, r_o/g_o/b_o=0, overflow_o=0.
  - Internal state: wr_sel=0, wr_addr=0, line_len=0, h_period=H_PERIOD_DEF, in_cnt=0, out_h=0, vs_pipe=0.
  - Reset asserted mid-line aborts the line immediately; the RAM contents need not be cleared.
- Input (write) side, only on ce_in:
  - in_cnt increments and saturates at 2^CNT_W-1.
  - If blank_i=0 and wr_addr<LINE_MAX: write rgb_i to buf[wr_sel][wr_addr], then wr_addr++.
  - If blank_i=0 and wr_addr=LINE_MAX: drop the pixel and set overflow_o=1.
- hsync_i rising edge (sampled on ce_in):
  - line_len <= wr_addr; wr_sel toggles; wr_addr <= 0; in_cnt <= 0.
  - h_period <= in_cnt+1 if in_cnt+1 >= MIN_PERIOD, otherwise h_period is unchanged.
  - vs_pipe <= vsync_i.
  - out_h is forced to 0, starting output line A of the pair.
- Output (read) side, only on ce_out:
  - out_h counts 0..h_period-1, then wraps to 0, starting line B.
  - The output line length equals h_period ce_out ticks, so the pair exactly fills one input line.
  - If hsync_i is absent, out_h keeps wrapping at h_period indefinitely (free-run).
- Read source: buf[~wr_sel], i.e. the line completed at the last input hsync.
- Read address = out_h - H_START while H_START <= out_h < H_START+line_len; otherwise the pixel is inactive.
- Pipeline: two ce_out stages (RAM read, then output register).
  - hsync_o, blank_o and colour are delayed identically, so all outputs align exactly two ce_out ticks after the out_h value that produced them.
- Output qualifiers:
  - hsync_o = (out_h < HS_W), delayed by the pipeline.
  - blank_o = 1 when inactive, when line_len=0, or when hsync_o=1.
  - When blank_o=1, r_o/g_o/b_o = 0.
- vsync_o = vs_pipe: it changes only at an input hsync edge, i.e. the output trails by one input line (two output lines).
- Colour expansion:
  - r_o = {R,R,R[2:1]}, g_o = {G,G,G[2:1]}, b_o = {B,B,B,B}.
- Simultaneous events:
  - Write and read always target different buffers, so there are no collisions.
  - An hsync edge on the same cycle as a read restarts out_h; the in-flight pipeline data still completes.
- ce_out=0 freezes all output registers; ce_in=0 freezes all write-side state.

Test Plan:
- Reset: assert reset mid-line -> blank_o=1, hsync_o=0, vsync_o=0, rgb outputs 0, overflow_o=0 in the same cycle. Release reset with no input -> out_h free-runs with period 384 ce_out ticks.
- Ramp: input line period 384 with 256 active pixels rgb_i=0..255 -> next two output lines each carry pixels 0..255 starting at out_h=H_START+2 ticks; hsync_o is high for 23 ticks; each output line is 384 ticks long.
- Colour: rgb_i=8'b10_101_110 -> r_o=8'hDB, g_o=8'hB6, b_o=8'hAA.
- Overflow: 600 active pixels -> only pixels 0..511 replayed, overflow_o=1 and stays 1 until reset.
- Vsync and bad period: vsync_i high for input lines N..N+2 -> vsync_o high for 6 output lines, starting at the hsync ending line N. A 20-tick glitch hsync -> h_period stays 384.
- Empty line: line with blank_i=1 throughout -> both output lines fully blanked, rgb 0.
